// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - instruction fetch/issue sequencer for 4-bit opcode program ROMs
//
// Purpose:
//   Owns the program counter and drives the ROM address. Registers each fetched
//   opcode and presents it to the datapath over a valid/ready handshake.
//   Applies SNZ skip-next from the datapath condition flag. Handles start,
//   halt and end-of-program.
//
// Optional feature macro: SEQ_CLR_HALT_EN
//   When defined, an issued CLR opcode (4'b0111) ends the program after its
//   handshake. When undefined, CLR is an ordinary instruction.
//
// Ports:
//   clk           in            single clock
//   reset         in            asynchronous active-high reset
//   startIn       in            pulse: begin/resume (IDLE) or restart from 0 (DONE)
//   haltIn        in            pulse: stop at the next instruction boundary
//   romAddrOut    out [AW-1:0]  ROM address, always equal to the PC
//   romDataIn     in  [3:0]     combinational ROM opcode at romAddrOut
//   instrOut      out [3:0]     registered opcode for the datapath
//   instrValidOut out           instrOut valid
//   instrReadyIn  in            datapath accepts instrOut
//   skipCondIn    in            SNZ condition, sampled at an SNZ handshake
//   pcOut         out [AW-1:0]  current PC
//   busyOut       out           FETCH or ISSUE
//   doneOut       out           DONE

module program_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int END_ADDR   = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startIn,
  input  logic                  haltIn,
  output logic [ADDR_WIDTH-1:0] romAddrOut,
  input  logic [3:0]            romDataIn,
  output logic [3:0]            instrOut,
  output logic                  instrValidOut,
  input  logic                  instrReadyIn,
  input  logic                  skipCondIn,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic                  busyOut,
  output logic                  doneOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_SNZ_A = 4'b1000;
  localparam logic [3:0] OP_SNZ_S = 4'b1001;
  localparam logic [3:0] OP_CLR   = 4'b0111;

  // One extra bit so a step past the top of the address space is visible
  // as "beyond END_ADDR" instead of wrapping back to a low address.
  localparam logic [ADDR_WIDTH:0] END_PC = (ADDR_WIDTH + 1)'(END_ADDR);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [3:0]            instr;
  logic                  halt_pend;

  logic                  is_snz;
  logic [1:0]            pc_step;
  logic [ADDR_WIDTH:0]   next_pc;
  logic                  end_prog;

  always_comb begin
    is_snz   = (instr == OP_SNZ_A) || (instr == OP_SNZ_S);
    pc_step  = (is_snz && skipCondIn) ? 2'd2 : 2'd1;
    next_pc  = {1'b0, pc} + {{(ADDR_WIDTH-1){1'b0}}, pc_step};
    end_prog = (next_pc > END_PC);
`ifdef SEQ_CLR_HALT_EN
    // Trailing CLR padding terminates the program once the CLR is accepted.
    if (instr == OP_CLR) begin
      end_prog = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      instr     <= OP_CLR;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A simultaneous halt cancels the start; the PC is kept for resume.
          if (startIn && !haltIn) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          instr <= romDataIn;
          state <= ISSUE;
          if (haltIn) begin
            halt_pend <= 1'b1;
          end
        end

        ISSUE: begin
          if (instrReadyIn) begin
            if (end_prog) begin
              // PC stays on the last issued address.
              state <= DONE;
            end else begin
              pc <= next_pc[ADDR_WIDTH-1:0];
              // A halt arriving on the handshake cycle itself is honoured too.
              if (halt_pend || haltIn) begin
                state     <= IDLE;
                halt_pend <= 1'b0;
              end else begin
                state <= FETCH;
              end
            end
          end else if (haltIn) begin
            halt_pend <= 1'b1;
          end
        end

        DONE: begin
          if (startIn) begin
            pc    <= '0;
            state <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come straight from registers or the state register, so reset
  // forces them to their idle values without waiting for a clock edge.
  assign romAddrOut    = pc;
  assign pcOut         = pc;
  assign instrOut      = instr;
  assign instrValidOut = (state == ISSUE);
  assign busyOut       = (state == FETCH) || (state == ISSUE);
  assign doneOut       = (state == DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer

module tb_program_sequencer;

  localparam int AW   = 4;
  localparam int ENDA = 14;

`ifdef SEQ_CLR_HALT_EN
  localparam bit CLR_HALT = 1'b1;
`else
  localparam bit CLR_HALT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startIn = 1'b0;
  logic          haltIn = 1'b0;
  logic [AW-1:0] romAddrOut;
  logic [3:0]    romDataIn;
  logic [3:0]    instrOut;
  logic          instrValidOut;
  logic          instrReadyIn = 1'b1;
  logic          skipCondIn;
  logic [AW-1:0] pcOut;
  logic          busyOut;
  logic          doneOut;

  logic [3:0] rom [16];
  bit         skip_tbl [16];

  assign romDataIn  = rom[romAddrOut];
  assign skipCondIn = skip_tbl[pcOut];

  program_sequencer #(.ADDR_WIDTH(AW), .END_ADDR(ENDA)) dut (
    .clk(clk), .reset(reset), .startIn(startIn), .haltIn(haltIn),
    .romAddrOut(romAddrOut), .romDataIn(romDataIn), .instrOut(instrOut),
    .instrValidOut(instrValidOut), .instrReadyIn(instrReadyIn),
    .skipCondIn(skipCondIn), .pcOut(pcOut), .busyOut(busyOut), .doneOut(doneOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    logic [3:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   run_id = 0;
  bit   tp_check = 1'b0;
  int   rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random
  int   end_pc;
  bit   end_done;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // Reference model: walk the program from start, at most maxn issues.
  function automatic void push_run(input int start, input int maxn);
    int p;
    int nxt;
    exp_t e;
    p = start;
    for (int n = 0; n < maxn; n++) begin
      e.addr = p;
      e.op   = rom[p];
      exp_q.push_back(e);
      nxt = p + 1;
      if ((rom[p] == 4'd8 || rom[p] == 4'd9) && skip_tbl[p]) nxt = p + 2;
      if (nxt > ENDA || (CLR_HALT && rom[p] == 4'd7)) begin
        end_pc   = p;
        end_done = 1'b1;
        return;
      end
      p = nxt;
    end
    end_pc   = p;
    end_done = 1'b0;
  endfunction

  function automatic void load_spec_rom();
    int spec [15] = '{0, 1, 10, 2, 11, 2, 14, 2, 3, 6, 8, 2, 2, 4, 2};
    for (int i = 0; i < 16; i++) begin
      rom[i]      = (i < 15) ? 4'(spec[i]) : 4'd0;
      skip_tbl[i] = 1'b0;
    end
  endfunction

  // Ready driver: updates just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       instrReadyIn = 1'b0;
        1:       instrReadyIn = 1'b1;
        default: instrReadyIn = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops an expectation at every observed handshake.
  int cyc = 0;
  int prev_cyc = 0;
  int prev_run = -1;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset && instrValidOut && instrReadyIn) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_pc", 32'(pcOut), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pc", 32'(pcOut), 32'(e.addr));
        chk("issue_op", 32'(instrOut), 32'(e.op));
      end
      if (tp_check && prev_run == run_id) chk("throughput", 32'(cyc - prev_cyc), 32'd2);
      prev_cyc = cyc;
      prev_run = run_id;
    end
  end

  task automatic do_start(input int exp_pc);
    run_id++;
    @(negedge clk);
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    chk("start_fetch_busy", 32'(busyOut), 32'd1);
    chk("start_fetch_valid", 32'(instrValidOut), 32'd0);
    chk("start_pc", 32'(pcOut), 32'(exp_pc));
    @(negedge clk);
    chk("start_issue_valid", 32'(instrValidOut), 32'd1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && !doneOut; i++) @(negedge clk);
    chk({name, "_done"}, 32'(doneOut), 32'd1);
    chk({name, "_end_pc"}, 32'(pcOut), 32'(end_pc));
    chk({name, "_model_end"}, 32'(end_done), 32'd1);
    chk({name, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    load_spec_rom();
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(pcOut), 32'd0);
    chk("rst_rom_addr", 32'(romAddrOut), 32'd0);
    chk("rst_instr", 32'(instrOut), 32'd7);
    chk("rst_valid", 32'(instrValidOut), 32'd0);
    chk("rst_busy", 32'(busyOut), 32'd0);
    chk("rst_done", 32'(doneOut), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busyOut), 32'd0);

    // Straight run of the reference program, ready tied high
    tp_check = 1'b1;
    rdy_mode = 1;
    push_run(0, 100);
    do_start(0);
    wait_done("straight");

    // SNZ skip at 10, restart from DONE
    skip_tbl[10] = 1'b1;
    push_run(0, 100);
    do_start(0);
    wait_done("skip10");

    // SNZ skip at END_ADDR-1 runs off the end
    rom[13] = 4'd8;
    skip_tbl[13] = 1'b1;
    push_run(0, 100);
    do_start(0);
    wait_done("skip_end");
    chk("skip_end_pc13", 32'(pcOut), 32'd13);

    // Halt during ISSUE at PC 5, then resume
    load_spec_rom();
    tp_check = 1'b0;
    push_run(0, 6);
    do_start(0);
    for (int i = 0; i < 100 && pcOut != 4'd5; i++) @(negedge clk);
    rdy_mode = 0;
    @(negedge clk);
    chk("halt_issue_pc5", 32'(pcOut), 32'd5);
    chk("halt_issue_valid", 32'(instrValidOut), 32'd1);
    haltIn = 1'b1;
    @(negedge clk);
    haltIn = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 50 && busyOut; i++) @(negedge clk);
    chk("halt_idle_busy", 32'(busyOut), 32'd0);
    chk("halt_idle_done", 32'(doneOut), 32'd0);
    chk("halt_idle_pc", 32'(pcOut), 32'd6);
    chk("halt_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    startIn = 1'b1;
    haltIn  = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    haltIn  = 1'b0;
    @(negedge clk);
    chk("start_halt_busy", 32'(busyOut), 32'd0);
    chk("start_halt_pc", 32'(pcOut), 32'd6);
    tp_check = 1'b1;
    push_run(6, 100);
    do_start(6);
    wait_done("resume");

    // CLR at address 3
    rom[3] = 4'd7;
    push_run(0, 100);
    do_start(0);
    wait_done("clr_rom");
`ifdef SEQ_CLR_HALT_EN
    chk("clr_stop_pc", 32'(pcOut), 32'd3);
`else
    chk("clr_runs_to_end_pc", 32'(pcOut), 32'd14);
`endif
    tp_check = 1'b0;

    // Randomized programs with backpressure and random ready
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
        skip_tbl[i] = ($urandom_range(0, 1) == 1);
      end
      rdy_mode = 0;
      push_run(0, 100);
      do_start(0);
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        chk("stall_valid", 32'(instrValidOut), 32'd1);
        chk("stall_instr", 32'(instrOut), 32'(rom[0]));
        chk("stall_pc", 32'(pcOut), 32'd0);
      end
      rdy_mode = 2;
      wait_done("random");
    end

    // Reset while an instruction is waiting in ISSUE
    load_spec_rom();
    rdy_mode = 1;
    push_run(0, 3);
    do_start(0);
    for (int i = 0; i < 100 && pcOut != 4'd3; i++) @(negedge clk);
    rdy_mode = 0;
    @(negedge clk);
    chk("pre_reset_valid", 32'(instrValidOut), 32'd1);
    chk("pre_reset_pc", 32'(pcOut), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(instrValidOut), 32'd0);
    chk("async_rst_instr", 32'(instrOut), 32'd7);
    chk("async_rst_pc", 32'(pcOut), 32'd0);
    chk("async_rst_busy", 32'(busyOut), 32'd0);
    chk("reset_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busyOut), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction-fetch and issue controller for the 4-bit opcode program ROMs. It owns the program counter and drives the ROM address, and it registers each fetched opcode. Each opcode is presented to the datapath over a valid/ready handshake. The block applies SNZ skip-next using a condition flag returned by the datapath, and it handles start, halt and end-of-program.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: width of the PC and ROM address.
- `END_ADDR`, default 2^ADDR_WIDTH-1: last executable address.

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: asynchronous, active-high reset.
- `startIn` in 1: one-cycle pulse. Begins or resumes execution.
- `haltIn` in 1: one-cycle pulse. Requests a stop at the next instruction boundary.
- `romAddrOut` out ADDR_WIDTH: ROM address. Always equals the PC.
- `romDataIn` in 4: combinational ROM opcode for `romAddrOut`.
- `instrOut` out 4: registered opcode presented to the datapath.
- `instrValidOut` out 1: `instrOut` is valid.
- `instrReadyIn` in 1: datapath accepts `instrOut` this cycle.
- `skipCondIn` in 1: datapath SNZ condition (selected register non-zero). Sampled only at the handshake of an SNZ opcode.
- `pcOut` out ADDR_WIDTH: current PC, for debug and display.
- `busyOut` out 1: high in FETCH or ISSUE.
- `doneOut` out 1: high in DONE.

## Operation
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - `startIn` moves to FETCH. The PC is retained, so execution resumes from the current PC.
  - `startIn` and `haltIn` in the same cycle: halt wins and the block stays in IDLE.
- FETCH (exactly 1 cycle):
  - `instrOut` <= `romDataIn`.
  - Then go to ISSUE.
- ISSUE:
  - `instrValidOut`=1.
  - `instrOut` is held stable until `instrValidOut`&`instrReadyIn`.
- PC update at the handshake:
  - Opcode 4'b1000 (SNZ A) or 4'b1001 (SNZ S) with `skipCondIn`=1: next = PC+2.
  - All other cases: next = PC+1.
  - Next PC is computed in ADDR_WIDTH+1 bits.
- After the handshake:
  - Next PC > END_ADDR: go to DONE. The PC is left at the last issued address.
  - Else, halt pending: load the next PC and go to IDLE.
  - Else: load the next PC and go to FETCH.
- Halt:
  - A `haltIn` pulse in FETCH or ISSUE sets `haltPend`. A `haltIn` pulse in IDLE or DONE is ignored.
  - `haltPend` is cleared on entry to IDLE.
  - An issued instruction is never withdrawn; halt takes effect only after the handshake.
- DONE:
  - `doneOut`=1.
  - `startIn` clears the PC to 0 and moves to FETCH. `doneOut` drops the next cycle.
- The PC never wraps silently. A skip past END_ADDR ends the program.
- `instrReadyIn` and `skipCondIn` are ignored outside ISSUE.

## Timing
- Reset values: state IDLE, PC 0, `romAddrOut` 0, `pcOut` 0, `instrOut` 4'b0111 (CLR), `instrValidOut` 0, `busyOut` 0, `doneOut` 0, `haltPend` 0.
- Reset mid-operation:
  - Outputs return to reset values immediately, asynchronously.
  - An in-flight instruction is dropped.
- Start latency: `startIn` high at edge N puts FETCH at N+1. `instrValidOut` rises after edge N+2.
- Throughput: one instruction per 2 cycles with `instrReadyIn` tied high. Each stall cycle adds 1 cycle.
- `romAddrOut` changes only on the handshake edge or the restart edge. The ROM has a full cycle to settle before FETCH captures.
- All outputs are registered, or decoded directly from the state register.

## Configuration
- `SEQ_CLR_HALT_EN` defined:
  - A fetched CLR opcode (4'b0111) is issued normally.
  - After its handshake, the block goes to DONE regardless of the next PC.
  - Trailing CLR/NOP padding therefore terminates the program early.
- `SEQ_CLR_HALT_EN` undefined: CLR is treated as an ordinary instruction, and execution continues to END_ADDR.

## Test plan
- Reset then start, ROM 0..14 = 0,1,10,2,11,2,14,2,3,6,8,2,2,4,2, `instrReadyIn`=1, `skipCondIn`=0, macro off, END_ADDR=14:
  - Issues 15 opcodes in order, one per 2 cycles.
  - `doneOut` rises after the handshake at address 14.
- SNZ skip, with `skipCondIn`=1 during the handshake at address 10 (opcode 8):
  - The next issued address is 12, not 11.
  - Skip at END_ADDR-1 goes to DONE with no further issue.
- Backpressure: `instrReadyIn` low for 3 cycles in ISSUE.
  - `instrValidOut` stays 1 and `instrOut` is stable.
  - The PC is unchanged until the ready cycle.
- Halt then resume: `haltIn` pulse during ISSUE at PC=5.
  - Opcode at 5 is still accepted, then IDLE with `pcOut`=6.
  - `startIn` resumes at 6.
  - `startIn`+`haltIn` together in IDLE leaves the block in IDLE.
- Restart and reset:
  - `startIn` in DONE gives PC 0 and re-runs from address 0.
  - `reset` asserted mid-ISSUE gives immediate `instrValidOut`=0 and `instrOut`=4'b0111.
- Macro on, ROM with CLR at address 3:
  - DONE follows the handshake at address 3, with `pcOut`=3.
  - Macro off: the same ROM runs to END_ADDR.
